// File: rtl/secret_digit_picker.sv
// Draws LFSR values until one converts to four distinct BCD digits, then
// publishes it as the 1A2B game secret. Gives up after MAX_TRIES values.
module secret_digit_picker #(
    parameter int unsigned MAX_TRIES          = 64,
    parameter bit          ALLOW_LEADING_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] ran,
    output logic        lfsr_en,
    output logic [15:0] secret,
    output logic        valid,
    output logic        fail,
    output logic        busy,
    output logic [7:0]  tries
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        CONVERT,
        CHECK,
        REJECT
    } state_t;

    localparam logic [7:0]  TRY_LIMIT = 8'(MAX_TRIES);
    localparam logic [13:0] MAX_VALUE = 14'd9999;

    state_t      state;
    logic [13:0] work;
    logic [15:0] bcd;
    logic [3:0]  bit_cnt;

    logic [15:0] bcd_adj;
    logic [29:0] shifted;
    logic [3:0]  d3, d2, d1, d0;
    logic        distinct;
    logic        leading_ok;

    // One double-dabble step: add-3 correction, then shift {bcd, work} left.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, work} << 1;
    end

    always_comb begin
        d3 = bcd[15:12];
        d2 = bcd[11:8];
        d1 = bcd[7:4];
        d0 = bcd[3:0];
        distinct = (d3 != d2) && (d3 != d1) && (d3 != d0) &&
                   (d2 != d1) && (d2 != d0) && (d1 != d0);
        leading_ok = ALLOW_LEADING_ZERO || (d3 != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            work    <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
            secret  <= '0;
            valid   <= 1'b0;
            fail    <= 1'b0;
            lfsr_en <= 1'b0;
            busy    <= 1'b0;
            tries   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        valid   <= 1'b0;
                        fail    <= 1'b0;
                        tries   <= '0;
                        lfsr_en <= 1'b1;
                        busy    <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    lfsr_en <= 1'b0;
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    work <= ran;
                    if (tries < TRY_LIMIT)
                        tries <= tries + 8'd1;
                    if (ran > MAX_VALUE) begin
                        state <= REJECT;
                    end else begin
                        bcd     <= '0;
                        bit_cnt <= 4'd14;
                        state   <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd     <= shifted[29:14];
                    work    <= shifted[13:0];
                    bit_cnt <= bit_cnt - 4'd1;
                    if (bit_cnt == 4'd1)
                        state <= CHECK;
                end
                CHECK: begin
                    if (distinct && leading_ok) begin
                        secret <= bcd;
                        valid  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        state <= REJECT;
                    end
                end
                REJECT: begin
                    if (tries == TRY_LIMIT) begin
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        lfsr_en <= 1'b1;
                        state   <= FETCH;
                    end
                end
                default: begin
                    lfsr_en <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/secret_digit_picker.md
Name: secret_digit_picker

Overview:
Consumer side of the 14-bit LFSR random source for the 1A2B game. On a start request, it pulls raw 14-bit values from the LFSR through a one-cycle enable handshake. Each value is range-checked, converted to four BCD digits with a sequential double-dabble, and checked for four distinct digits. The first value that passes every check is published as the game secret; values that fail are discarded and another value is fetched, up to a try limit.

Parameters:
MAX_TRIES, 64, number of LFSR values consumed before giving up (1..255)
ALLOW_LEADING_ZERO, 1, 1 = thousands digit may be 0; 0 = values with thousands digit 0 are rejected

Ports:
clk  input  1  clock
rst  input  1  reset: synchronous, active-high; clock clk
start  input  1  request a new secret; sampled only in IDLE
ran  input  14  raw value from LFSR; valid on the cycle after lfsr_en was high
lfsr_en  output  1  one-cycle request to advance the LFSR
secret  output  16  four BCD digits, [15:12]=thousands .. [3:0]=units
valid  output  1  secret holds an accepted value
fail  output  1  MAX_TRIES values consumed with no acceptance
busy  output  1  high in every state except IDLE
tries  output  8  LFSR values consumed in the current request

Behaviour:
- Reset values: state IDLE; secret=0, valid=0, fail=0, lfsr_en=0, tries=0, busy=0, internal shift/BCD registers=0.
- Reset asserted mid-operation aborts the request immediately. There is no residual lfsr_en pulse after reset.
- FSM states and transitions:
  - IDLE: if start=1, clear valid, fail and tries, then go to FETCH. Otherwise stay; valid, fail and secret hold.
  - FETCH (1 cycle): lfsr_en=1 (Moore, high only in this state), then go to CAPTURE.
  - CAPTURE (1 cycle): latch ran into a 14-bit work register and increment tries.
    - If ran > 9999, go to REJECT.
    - Otherwise clear the 16-bit BCD accumulator, load a bit counter with 14, and go to CONVERT.
  - CONVERT (exactly 14 cycles): double-dabble, MSB first.
    - Each cycle, first add 3 to every BCD nibble that is ≥5.
    - Then shift {bcd, work} left by 1.
    - After the 14th shift, go to CHECK.
  - CHECK (1 cycle): accept iff all six digit pairs differ and (ALLOW_LEADING_ZERO=1 or thousands digit ≠ 0).
    - On accept: secret <= bcd, valid <= 1, go to IDLE.
    - On reject: go to REJECT.
  - REJECT (1 cycle): if tries == MAX_TRIES, set fail <= 1, leave secret unchanged, go to IDLE. Otherwise go to FETCH.
- Latency, best case (first value accepted):
  - start sampled at edge E0.
  - FETCH in cycle 1, CAPTURE in cycle 2, CONVERT in cycles 3–16, CHECK in cycle 17.
  - valid is high from edge E17.
  - Each rejected value adds 3 cycles if rejected by the range check, or 18 cycles if rejected by CHECK.
- start while busy=1 is ignored, with no queuing.
- tries saturates at MAX_TRIES and is never compared beyond it.
- valid and fail are mutually exclusive, and both are level outputs held until the next accepted start or rst.
- The LFSR's done output is not consumed. A wrapped sequence is simply more tries.
- Boundary values for the range check:
  - ran=9999 is in range; it then fails CHECK because its digits repeat.
  - ran=10000 is rejected by the range check.
  - ran=0 is range-valid; it fails CHECK.

Test Plan:
1. rst, then start with ran=14'd1234 presented the cycle after lfsr_en → exactly one lfsr_en pulse; valid rises at E17; secret=16'h1234; tries=1; fail=0.
2. ran sequence 1123, then 5678 → two lfsr_en pulses, 18 cycles apart; secret=16'h5678; tries=2; valid at E35.
3. ran sequence 12000, 16383, then 9876 → first two rejected at CAPTURE (3 cycles each); secret=16'h9876; tries=3.
4. MAX_TRIES=2, ran always 10000 → fail=1, valid=0, tries=2, busy=0; secret retains its previous value; a new start clears fail.
5. ALLOW_LEADING_ZERO=0, ran sequence 0123, then 4023 → 0123 rejected, secret=16'h4023. With ALLOW_LEADING_ZERO=1, 0123 → secret=16'h0123.
6. rst pulsed during CONVERT cycle 7 → next cycle: busy=0, valid=0, lfsr_en=0, tries=0. start pulsed while busy → ignored, lfsr_en count unchanged.
